sram_device_model: RTL
======================

Name: sram_device_model

Overview:
- Cycle-accurate responder for the external 16-bit asynchronous-SRAM pin interface that the memory stage's SRAM controller drives.
- Sits on the far side of SRAM_DQ/SRAM_ADDR/control pins in simulation and FPGA loopback benches.
- Stores data, honours byte lanes, and returns read data on the shared bidirectional bus after a programmable latency.
- Keeps access counters and a sticky protocol-violation flag for verification.

Parameters:
- MEM_AW, 18, number of address bits actually decoded; array depth is 2**MEM_AW 16-bit words.
- READ_LAT, 2, clock cycles from a sampled read to data on SRAM_DQ; legal range 1..4.

Ports:
- clk  input  1  system clock; all pin sampling on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- SRAM_DQ  inout  16  shared data bus; driven only per the read rules below, otherwise high-Z.
- SRAM_ADDR  input  18  word address; bits [17:MEM_AW] ignored (aliasing).
- SRAM_UB_N  input  1  active-low upper byte lane enable, DQ[15:8].
- SRAM_LB_N  input  1  active-low lower byte lane enable, DQ[7:0].
- SRAM_WE_N  input  1  active-low write enable.
- SRAM_CE_N  input  1  active-low chip enable.
- SRAM_OE_N  input  1  active-low output enable.
- rd_cnt  output  16  number of read launches, wraps 0xFFFF->0.
- wr_cnt  output  16  number of write commits, wraps 0xFFFF->0.
- conflict  output  1  sticky flag: WE_N and OE_N both low while CE_N low was sampled.

Behaviour:
- Reset (rst=0, async):
  - Read pipeline valid bits cleared; SRAM_DQ released to Z immediately.
  - rd_cnt=0, wr_cnt=0, conflict=0.
  - Array contents are NOT cleared and survive reset, including reset asserted mid-access.
- Sampled conditions, evaluated each rising edge:
  - WR = !CE_N & !WE_N.
  - RD = !CE_N & WE_N & !OE_N.
  - CE_N=1 means idle: no array change, no launch, no count.
- Write (WR sampled):
  - mem[ADDR[MEM_AW-1:0]][7:0] <= DQ[7:0] if !LB_N.
  - mem[ADDR[MEM_AW-1:0]][15:8] <= DQ[15:8] if !UB_N.
  - wr_cnt increments even if both lanes are disabled.
  - The write is visible to any read launched on the next edge or later.
- Conflict:
  - WR with OE_N=0 sets conflict=1, held until reset.
  - The write still occurs; no read is launched.
- Read (RD sampled):
  - Launches a read: pipeline stage 0 captures valid=1, data=mem[addr] (pre-write contents; a same-edge write is impossible because RD excludes WR).
  - rd_cnt increments.
  - Pipeline shifts one stage per cycle, READ_LAT stages deep.
  - Non-RD edges insert valid=0.
- Output drive, combinational on current pins:
  - DQ[7:0] driven with tail data[7:0] iff tail valid & !CE_N & WE_N & !OE_N & !LB_N.
  - DQ[15:8] driven likewise under !UB_N.
  - Each lane is high-Z otherwise, so deasserting OE_N, CE_N or a lane enable releases the bus in the same cycle.
- Latency and throughput:
  - A read sampled at edge N drives DQ during the cycle after edge N+READ_LAT-1.
  - With READ_LAT=1, data appears in the cycle directly following the sampling edge.
  - Back-to-back reads give one word per cycle after the initial latency.
- Pipeline and bus turnaround:
  - A write sampled while read data is still in flight flushes nothing; stale tail data is simply not driven because WE_N=0.
  - The tail data is driven again only if RD conditions return while it is still valid.
- Address wrap: addresses beyond 2**MEM_AW-1 alias modulo depth.
- Counter overflow: 0xFFFF + 1 = 0x0000, no flag.
- Uninitialised words read as X in simulation; the bench must write before reading.

Test Plan:
- Write then read, READ_LAT=2: write 0xBEEF to addr 0x00010 with both lanes enabled, then RD at 0x00010 sampled at edge N. Required: DQ Z through the cycle after edge N, DQ=0xBEEF after edge N+1, rd_cnt=1, wr_cnt=1.
- Byte lanes: write 0x1234 to addr 5, then write 0xAB00 with LB_N=1, UB_N=0. Read with both lanes gives 0xAB34. Read with UB_N=1 drives DQ[15:8]=Z and DQ[7:0]=0x34.
- Streaming: write addrs 0..3 = 0x0000..0x0003, then 4 consecutive RD cycles. Required: DQ presents 0,1,2,3 on consecutive cycles starting READ_LAT cycles after the first sample; rd_cnt=4.
- Conflict and bus release: CE_N=0, WE_N=0, OE_N=0 with DQ=0x5555 at addr 7. Required: conflict=1 and stays 1, and the model never drives DQ that cycle. A later read of addr 7 returns 0x5555. Raising OE_N mid-read releases DQ to Z the same cycle.
- Reset mid-read: launch a read of 0xBEEF, assert rst=0 before data emerges. Required: DQ Z immediately, counters 0, conflict 0. After release, re-read of addr 0x00010 still returns 0xBEEF.
- Aliasing and wrap, MEM_AW=4: write 0x00AA to addr 0x00013, read addr 0x00003 gives 0x00AA. Issue 65536 writes: wr_cnt wraps to 0.

Source files
------------

// File: rtl/sram_device_model.sv
// Behavioural responder for a 16-bit asynchronous-SRAM pin interface.
// Samples the pins on every rising edge, stores writes with byte-lane
// masking, and returns read data on the shared bus after READ_LAT cycles.
// Read/write counters and a sticky WE/OE overlap flag are exposed so that
// a bench can check how the controller behaves on the pins.
//
// The array has no reset, so its contents survive rst. Only the read
// pipeline valid bits, the counters and the flag are cleared.

module sram_device_model #(
   parameter int MEM_AW   = 18,
   parameter int READ_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   inout  wire  [15:0] SRAM_DQ,
   input  logic [17:0] SRAM_ADDR,
   input  logic        SRAM_UB_N,
   input  logic        SRAM_LB_N,
   input  logic        SRAM_WE_N,
   input  logic        SRAM_CE_N,
   input  logic        SRAM_OE_N,
   output logic [15:0] rd_cnt,
   output logic [15:0] wr_cnt,
   output logic        conflict
);

   localparam int DEPTH = 1 << MEM_AW;

   logic [15:0]       mem [DEPTH];
   logic [MEM_AW-1:0] addr;
   logic              wr_s;
   logic              rd_s;
   logic              cf_s;

   logic [READ_LAT-1:0] pipe_vld;
   logic [15:0]         pipe_dat [READ_LAT];

   logic        tail_vld;
   logic [15:0] tail_dat;
   logic        drive_lo;
   logic        drive_hi;

   // Address bits above MEM_AW are not decoded, so the array aliases.
   assign addr = SRAM_ADDR[MEM_AW-1:0];

   if (MEM_AW < 18) begin : g_alias
      logic [17-MEM_AW:0] unused_addr_hi;
      assign unused_addr_hi = SRAM_ADDR[17:MEM_AW];
   end

   // Decoded pin conditions. A read requires WE_N high, so a read and a
   // write can never be sampled on the same edge.
   assign wr_s = !SRAM_CE_N && !SRAM_WE_N;
   assign rd_s = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;
   assign cf_s = wr_s && !SRAM_OE_N;

   // Control state: read pipeline valid bits, access counters and the
   // sticky conflict flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_vld <= '0;
         rd_cnt   <= 16'd0;
         wr_cnt   <= 16'd0;
         conflict <= 1'b0;
      end else begin
         pipe_vld[0] <= rd_s;
         for (int i = 1; i < READ_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
         end
         if (rd_s) begin
            rd_cnt <= rd_cnt + 16'd1;
         end
         if (wr_s) begin
            wr_cnt <= wr_cnt + 16'd1;
         end
         if (cf_s) begin
            conflict <= 1'b1;
         end
      end
   end

   // Storage array and read data pipeline. Stage 0 always captures the
   // pre-write contents of the addressed word, and the valid bits decide
   // whether that capture is ever driven onto the bus.
   always_ff @(posedge clk) begin
      if (wr_s) begin
         if (!SRAM_LB_N) begin
            mem[addr][7:0] <= SRAM_DQ[7:0];
         end
         if (!SRAM_UB_N) begin
            mem[addr][15:8] <= SRAM_DQ[15:8];
         end
      end
      pipe_dat[0] <= mem[addr];
      for (int i = 1; i < READ_LAT; i++) begin
         pipe_dat[i] <= pipe_dat[i-1];
      end
   end

   assign tail_vld = pipe_vld[READ_LAT-1];
   assign tail_dat = pipe_dat[READ_LAT-1];

   // Drive decision follows the live pins, so dropping OE_N, CE_N or a
   // lane enable releases that lane in the same cycle.
   assign drive_lo = tail_vld && rd_s && !SRAM_LB_N;
   assign drive_hi = tail_vld && rd_s && !SRAM_UB_N;

   assign SRAM_DQ[7:0]  = drive_lo ? tail_dat[7:0]  : 8'hzz;
   assign SRAM_DQ[15:8] = drive_hi ? tail_dat[15:8] : 8'hzz;

endmodule
